// File: rtl/rename_pkg.sv
// rename_pkg: sizes and tag/arch-register types shared by the rename
// controller, the ROB and the issue logic.
package rename_pkg;

    localparam int NUM_AREGS = 32;
    localparam int NUM_PREGS = 64;
    localparam int PTAG_W    = $clog2(NUM_PREGS);

    typedef logic [PTAG_W-1:0] ptag_t;
    typedef logic [4:0]        areg_t;

    // Every architectural register always owns exactly one committed tag,
    // so the committed view always leaves this many tags free.
    localparam logic [PTAG_W:0] COMMITTED_FREE_COUNT = (PTAG_W+1)'(NUM_PREGS - NUM_AREGS);

endpackage

// File: rtl/freelist_pri_enc.sv
// freelist_pri_enc: find-lowest-set over the free-tag bit vector.
module freelist_pri_enc
    import rename_pkg::*;
(
    input  logic [NUM_PREGS-1:0] req_i,
    output ptag_t                idx_o,
    output logic                 found_o
);

    // Scan from the top down so that the last hit kept is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = NUM_PREGS - 1; i >= 0; i--) begin
            idx_o   = req_i[i] ? ptag_t'(i) : idx_o;
            found_o = found_o | req_i[i];
        end
    end

endmodule

// File: rtl/rename_map_ctrl.sv
// rename_map_ctrl: renames the rename-queue head through a speculative RAT,
// allocates destination tags from a bit-vector free list, reclaims tags at
// commit and rebuilds speculative state from the committed RAT on flush.
// Optional build macro RENAME_FREELIST_CHECK_EN adds double-free detection.
module rename_map_ctrl
    import rename_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              flush,
    input  logic              Instr_Valid_IN,
    input  logic              RegWrite_IN,
    input  areg_t             ReadRegisterA_IN,
    input  areg_t             ReadRegisterB_IN,
    input  areg_t             WriteRegister_IN,
    input  logic              Commit_Valid_IN,
    input  areg_t             Commit_ArchReg_IN,
    input  ptag_t             Commit_PhysDest_IN,
    input  ptag_t             Commit_OldPhysDest_IN,
    output logic              RN_STALL,
    output logic              Renamed_Valid_OUT,
    output ptag_t             PhysA_OUT,
    output ptag_t             PhysB_OUT,
    output ptag_t             PhysDest_OUT,
    output ptag_t             OldPhysDest_OUT,
    output logic              Renamed_RegWrite_OUT,
    output logic [PTAG_W:0]   FreeCount_OUT,
    output logic              FreeList_Error_OUT
);

    ptag_t                 rat_q  [NUM_AREGS];
    ptag_t                 rat_d  [NUM_AREGS];
    ptag_t                 crat_q [NUM_AREGS];
    ptag_t                 crat_d [NUM_AREGS];
    logic [NUM_PREGS-1:0]  free_q, free_d;
    logic [NUM_PREGS-1:0]  cused_q, cused_d;
    logic [PTAG_W:0]       count_q, count_d;

    logic                  valid_q, valid_d;
    ptag_t                 phys_a_q, phys_a_d;
    ptag_t                 phys_b_q, phys_b_d;
    ptag_t                 phys_dest_q, phys_dest_d;
    ptag_t                 old_dest_q, old_dest_d;
    logic                  regwrite_q, regwrite_d;

    logic                  needs_dest_s;
    logic                  fire_s;
    logic                  alloc_s;
    logic                  flush_s;
    logic                  commit_ok_s;
    logic                  commit_free_s;
    logic                  dbl_free_s;
    ptag_t                 alloc_tag_s;
    logic                  found_s;

    freelist_pri_enc u_pri_enc (
        .req_i   (free_q),
        .idx_o   (alloc_tag_s),
        .found_o (found_s)
    );

    assign needs_dest_s  = RegWrite_IN && (WriteRegister_IN != 5'd0);
    assign RN_STALL      = Instr_Valid_IN && needs_dest_s && (count_q == '0);
    assign flush_s       = flush && !STALL;
    assign fire_s        = !STALL && !flush && Instr_Valid_IN && !RN_STALL;
    assign alloc_s       = fire_s && needs_dest_s && found_s;
    assign commit_ok_s   = Commit_Valid_IN && (Commit_ArchReg_IN != 5'd0);

`ifdef RENAME_FREELIST_CHECK_EN
    // Freeing a tag that is already free means the ROB and free list disagree.
    assign dbl_free_s = commit_ok_s && free_q[Commit_OldPhysDest_IN];
`else
    assign dbl_free_s = 1'b0;
`endif
    assign commit_free_s = commit_ok_s && !dbl_free_s;

    // Next-state: commit always applies; flush wins over rename; STALL freezes rename outputs.
    always_comb begin
        rat_d       = rat_q;
        crat_d      = crat_q;
        free_d      = free_q;
        cused_d     = cused_q;
        count_d     = count_q + (PTAG_W+1)'(commit_free_s) - (PTAG_W+1)'(alloc_s);
        valid_d     = valid_q;
        phys_a_d    = phys_a_q;
        phys_b_d    = phys_b_q;
        phys_dest_d = phys_dest_q;
        old_dest_d  = old_dest_q;
        regwrite_d  = regwrite_q;

        if (commit_ok_s) begin
            crat_d[Commit_ArchReg_IN]      = Commit_PhysDest_IN;
            cused_d[Commit_PhysDest_IN]    = 1'b1;
            cused_d[Commit_OldPhysDest_IN] = 1'b0;
        end else begin
            cused_d = cused_q;
        end

        if (commit_free_s) begin
            free_d[Commit_OldPhysDest_IN] = 1'b1;
        end else begin
            free_d = free_q;
        end

        if (flush_s) begin
            rat_d   = crat_d;
            free_d  = ~cused_d;
            count_d = COMMITTED_FREE_COUNT;
            valid_d = 1'b0;
        end else if (STALL) begin
            valid_d = valid_q;
        end else if (fire_s) begin
            // Sources read the pre-update map, so self-reads see the old mapping.
            phys_a_d = (ReadRegisterA_IN == 5'd0) ? ptag_t'(0) : rat_q[ReadRegisterA_IN];
            phys_b_d = (ReadRegisterB_IN == 5'd0) ? ptag_t'(0) : rat_q[ReadRegisterB_IN];
            valid_d  = 1'b1;
            if (alloc_s) begin
                phys_dest_d             = alloc_tag_s;
                old_dest_d              = rat_q[WriteRegister_IN];
                regwrite_d              = 1'b1;
                rat_d[WriteRegister_IN] = alloc_tag_s;
                free_d[alloc_tag_s]     = 1'b0;
            end else begin
                phys_dest_d = '0;
                old_dest_d  = '0;
                regwrite_d  = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and registered outputs; reset gives identity maps and tags 32..63 free.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                rat_q[i]  <= ptag_t'(i);
                crat_q[i] <= ptag_t'(i);
            end
            free_q      <= {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
            cused_q     <= {{(NUM_PREGS-NUM_AREGS){1'b0}}, {NUM_AREGS{1'b1}}};
            count_q     <= COMMITTED_FREE_COUNT;
            valid_q     <= 1'b0;
            phys_a_q    <= '0;
            phys_b_q    <= '0;
            phys_dest_q <= '0;
            old_dest_q  <= '0;
            regwrite_q  <= 1'b0;
        end else begin
            rat_q       <= rat_d;
            crat_q      <= crat_d;
            free_q      <= free_d;
            cused_q     <= cused_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            phys_a_q    <= phys_a_d;
            phys_b_q    <= phys_b_d;
            phys_dest_q <= phys_dest_d;
            old_dest_q  <= old_dest_d;
            regwrite_q  <= regwrite_d;
        end
    end

`ifdef RENAME_FREELIST_CHECK_EN
    logic err_q;

    // Sticky double-free flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | dbl_free_s;
        end
    end

    // Report each double free as it happens.
    always_ff @(posedge CLK) begin
        if (!RESET && dbl_free_s) begin
            $error("rename_map_ctrl: double free of tag %0d", Commit_OldPhysDest_IN);
        end
    end

    assign FreeList_Error_OUT = err_q;
`else
    assign FreeList_Error_OUT = 1'b0;
`endif

    assign Renamed_Valid_OUT    = valid_q;
    assign PhysA_OUT            = phys_a_q;
    assign PhysB_OUT            = phys_b_q;
    assign PhysDest_OUT         = phys_dest_q;
    assign OldPhysDest_OUT      = old_dest_q;
    assign Renamed_RegWrite_OUT = regwrite_q;
    assign FreeCount_OUT        = count_q;

endmodule

// File: doc/rename_map_ctrl.md
# rename_map_ctrl

Register-rename controller that sits directly after the rename queue and sequences its head entry. It maps architectural source and destination registers to physical tags using a speculative rename table (RAT). Destination tags come from a bit-vector free list. The block back-pressures the queue with RN_STALL when no physical register is available, reclaims tags at commit, and rebuilds speculative state from a committed RAT on flush.

## Interface
- NUM_AREGS, 32, architectural registers (5-bit index)
- NUM_PREGS, 64, physical registers; must exceed NUM_AREGS
- PTAG_W, 6, physical tag width, clog2(NUM_PREGS)
- CLK  in  1  clock; all state on rising edge
- RESET  in  1  synchronous, active-high reset
- STALL  in  1  global pipeline stall; freezes rename and flush handling
- flush  in  1  misprediction flush; restore speculative state
- Instr_Valid_IN  in  1  rename-queue head valid
- RegWrite_IN  in  1  head writes a register
- ReadRegisterA_IN / ReadRegisterB_IN  in  5  source arch regs
- WriteRegister_IN  in  5  destination arch reg
- Commit_Valid_IN  in  1  one instruction retires this cycle
- Commit_ArchReg_IN  in  5  retiring destination arch reg
- Commit_PhysDest_IN / Commit_OldPhysDest_IN  in  PTAG_W  retiring new and previous tags
- RN_STALL  out  1  combinational; head cannot be renamed this cycle
- Renamed_Valid_OUT  out  1  registered rename result valid
- PhysA_OUT / PhysB_OUT  out  PTAG_W  source tags
- PhysDest_OUT / OldPhysDest_OUT  out  PTAG_W  allocated tag and previous mapping (forwarded to ROB)
- Renamed_RegWrite_OUT  out  1  allocation performed
- FreeCount_OUT  out  PTAG_W+1  free tags available
- FreeList_Error_OUT  out  1  sticky double-free flag (see Configuration)

## Operation
- needs_dest = RegWrite_IN && WriteRegister_IN != 0. Arch r0 is never renamed and always reads physical tag 0.
- RN_STALL = Instr_Valid_IN && needs_dest && FreeCount == 0. This is the queue's RN_STALL input; the head is consumed in any cycle where RN_STALL = 0.
- Rename fires when !STALL && !flush && Instr_Valid_IN && !RN_STALL:
  - Sources read the RAT before the destination update, so an instruction reading its own destination gets the old mapping.
  - If needs_dest: allocate the lowest-index free tag T, clear free[T], set OldPhysDest = RAT[dst], set RAT[dst] = T.
  - If not needs_dest: PhysDest_OUT = 0, OldPhysDest_OUT = 0, Renamed_RegWrite_OUT = 0.
- Commit is processed every cycle, independent of STALL:
  - Set free[Commit_OldPhysDest_IN].
  - Set committed RAT[arch] = Commit_PhysDest_IN.
  - Update committed_used: set the new tag, clear the old tag.
  - Commit with arch 0 is ignored.
- Flush (only when !STALL) takes priority over rename:
  - Set spec RAT = committed RAT, free = ~committed_used, Renamed_Valid_OUT = 0.
  - These values include any commit in the same cycle.
- FreeCount_next = FreeCount + commit_free − alloc. It is a maintained counter, not a popcount, and saturates neither way.

## Timing
- Reset values:
  - RAT[i] = i and committed RAT[i] = i.
  - free = tags NUM_AREGS..NUM_PREGS−1; committed_used = tags 0..NUM_AREGS−1.
  - FreeCount = 32.
  - All outputs 0 except FreeCount_OUT = 32.
- Rename latency: 1 cycle; outputs are registered at the edge the rename fires.
- STALL: all outputs and RAT hold; Renamed_Valid_OUT holds its value.
- Idle or stalled-by-RN_STALL cycle (not STALL): Renamed_Valid_OUT = 0.
- Commit and allocation in the same cycle: the freed tag becomes allocatable the next cycle.
- At FreeCount = 0 with a same-cycle commit: RN_STALL stays 1 that cycle, and the freed tag is allocated the cycle after.
- Reset mid-operation has priority over flush, commit and rename.

## Configuration
- RENAME_FREELIST_CHECK_EN defined:
  - A commit whose Commit_OldPhysDest_IN is already free sets FreeList_Error_OUT (sticky until RESET).
  - The free bit and FreeCount are left unchanged for that commit.
  - Simulation $error is issued.
- Undefined: the check logic is removed, FreeList_Error_OUT is tied 0, and the commit frees unconditionally.

## Structure
- rename_pkg holds the following, shared with the ROB and issue logic:
  - NUM_AREGS, NUM_PREGS, PTAG_W.
  - typedef ptag_t, logic [PTAG_W-1:0].
  - typedef areg_t, logic [4:0].
- Sub-module freelist_pri_enc: combinational find-lowest-set over NUM_PREGS bits, outputs the index and a found flag.
- The RAT, committed RAT, free and committed_used vectors, and the counter live in rename_map_ctrl.

## Test plan
- Reset, then rename 3 instructions in consecutive cycles:
  - Stimulus: r1 ← r2,r3; r4 ← r1,r1; r1 ← r1,r0.
  - Required: dest tags 32, 33, 34.
  - Required: second instruction sources = 32,32.
  - Required: third instruction sources = 32,0 with OldPhysDest = 32.
  - Required: FreeCount_OUT = 29.
- 32 back-to-back renames to r5 with no commit:
  - Required: the 33rd sees RN_STALL = 1, FreeCount_OUT = 0, Renamed_Valid_OUT = 0.
- While stalled at FreeCount = 0, commit frees tag 40:
  - Required: RN_STALL = 1 that cycle, 0 the next.
  - Required: PhysDest_OUT = 40 one cycle later.
- Rename r7 → 32, commit nothing, assert flush:
  - Required next cycle: r7 reads tag 7 and FreeCount_OUT = 32.
- Flush plus commit in the same cycle (arch 7, new 32, old 7):
  - Required: r7 reads 32 and FreeCount_OUT = 32 (tag 7 freed, 32 used).
- With RENAME_FREELIST_CHECK_EN, commit old tag 50 while 50 is free:
  - Required: FreeList_Error_OUT = 1 next cycle and FreeCount_OUT unchanged.
